// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: widths, FSM state
// encoding, latched operation encoding and the request decode helper.
package data_mem_responder_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int CNT_W           = 4;
    localparam int MEM_DEPTH       = 256;
    localparam int DEFAULT_LATENCY = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } op_t;

    // Write wins when both request lines are high at acceptance.
    function automatic op_t decode_op(input logic rd, input logic wr);
        op_t op;
        if (wr) begin
            op = OP_WRITE;
        end else if (rd) begin
            op = OP_READ;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// 256 x 8 storage: synchronous write, combinational indexed read and an
// asynchronous active-low clear of every byte.
module mem_array_256x8
    import data_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    // Storage update: clear all bytes on reset, otherwise commit writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder. A CPU read/write is accepted in IDLE,
// held in BUSY for LATENCY edges while a counter runs down, committed on the
// last BUSY edge and followed by a single DONE cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    op_t               op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              req_s;
    logic              last_s;

    assign req_s  = READ | WRITE;
    assign last_s = (cnt_r == {CNT_W{1'b0}});

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, one DONE cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Outputs: stall follows the request in IDLE, forced high in BUSY, low in DONE.
    always_comb begin
        BUSYWAIT = 1'b0;
        mem_we_s = 1'b0;
        case (state_r)
            ST_IDLE: BUSYWAIT = req_s;
            ST_BUSY: begin
                BUSYWAIT = 1'b1;
                mem_we_s = last_s && (op_r == OP_WRITE);
            end
            ST_DONE: BUSYWAIT = 1'b0;
            default: BUSYWAIT = 1'b0;
        endcase
    end

    // Datapath: latch the request at acceptance, run the counter, capture reads.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= OP_NONE;
            addr_r   <= {ADDR_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
            READDATA <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        op_r   <= decode_op(READ, WRITE);
                        addr_r <= ADDRESS;
                        data_r <= WRITEDATA;
                        cnt_r  <= LOAD_VAL;
                    end
                end
                ST_BUSY: begin
                    if (!last_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (op_r == OP_READ) begin
                        READDATA <= mem_rdata_s;
                    end
                end
                ST_DONE: op_r <= OP_NONE;
                default: op_r <= OP_NONE;
            endcase
        end
    end

    mem_array_256x8 u_mem (
        .clk   (CLK),
        .rst_n (RESET),
        .we    (mem_we_s),
        .addr  (addr_r),
        .wdata (data_r),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY 5 and 1) driven by directed
// and randomized accesses, checked against a simple array-based model.
module tb_data_mem_responder;

    logic       clk;
    logic       rst_n;
    logic       rd_in    [2];
    logic       wr_in    [2];
    logic [7:0] addr_in  [2];
    logic [7:0] wdata_in [2];
    logic [7:0] rdata_out[2];
    logic       busy_out [2];

    int         n_vec;
    int         n_err;
    logic [7:0] model_mem [2][256];
    logic [7:0] model_rd  [2];
    int         lat       [2];

    data_mem_responder #(.LATENCY(5)) u_dut0 (
        .CLK       (clk),
        .RESET     (rst_n),
        .READ      (rd_in[0]),
        .WRITE     (wr_in[0]),
        .ADDRESS   (addr_in[0]),
        .WRITEDATA (wdata_in[0]),
        .READDATA  (rdata_out[0]),
        .BUSYWAIT  (busy_out[0])
    );

    data_mem_responder #(.LATENCY(1)) u_dut1 (
        .CLK       (clk),
        .RESET     (rst_n),
        .READ      (rd_in[1]),
        .WRITE     (wr_in[1]),
        .ADDRESS   (addr_in[1]),
        .WRITEDATA (wdata_in[1]),
        .READDATA  (rdata_out[1]),
        .BUSYWAIT  (busy_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model_mem[s][i] = 8'h00;
            model_rd[s] = 8'h00;
        end
    endtask

    task automatic idle(input int s, input int n);
        @(negedge clk);
        rd_in[s] = 1'b0;
        wr_in[s] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // One complete access; returns #1 after the completing edge with the request still held.
    task automatic access(input int s, input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input int exp_gap, input bit scramble,
                          input string tag);
        int gap;
        int edges;
        @(negedge clk);
        rd_in[s]    = rd;
        wr_in[s]    = wr;
        addr_in[s]  = a;
        wdata_in[s] = d;
        #1;
        gap = 0;
        while (!busy_out[s] && gap < 4) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check({tag, " gap"}, gap, exp_gap);
        edges = 0;
        while (busy_out[s] && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (scramble && busy_out[s]) begin
                addr_in[s]  = 8'($urandom);
                wdata_in[s] = 8'($urandom);
            end
        end
        check({tag, " stall"}, edges, lat[s] + 1);
        if (wr) begin
            model_mem[s][a] = d;
        end else if (rd) begin
            model_rd[s] = model_mem[s][a];
        end
        check({tag, " rdata"}, rdata_out[s], model_rd[s]);
        check({tag, " done busy"}, busy_out[s], 1'b0);
    endtask

    initial begin
        int   op;
        bit   b2b;
        logic [7:0] a;
        n_vec  = 0;
        n_err  = 0;
        lat[0] = 5;
        lat[1] = 1;
        clear_model();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd_in[s] = 1'b0; wr_in[s] = 1'b0; addr_in[s] = 8'h00; wdata_in[s] = 8'h00;
        end
        #22;
        check("reset rdata0", rdata_out[0], 8'h00);
        check("reset rdata1", rdata_out[1], 8'h00);
        check("reset busy0", busy_out[0], 1'b0);
        check("reset busy1", busy_out[1], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum latency instance: read of cleared storage.
        access(1, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0, "lat1 rd00");
        idle(1, 1);

        // Write / read-back, address hold under scrambled inputs.
        access(0, 1'b0, 1'b1, 8'h10, 8'hA5, 0, 1'b0, "wr10");
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, 1, 1'b0, "rd10");
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, 1, 1'b1, "addrhold");

        // Read/write conflict: write wins, READDATA untouched.
        access(0, 1'b0, 1'b1, 8'h30, 8'h77, 1, 1'b0, "wr30");
        access(0, 1'b1, 1'b0, 8'h30, 8'h00, 1, 1'b0, "rd30");
        access(0, 1'b1, 1'b1, 8'h20, 8'h3C, 1, 1'b0, "conflict");
        access(0, 1'b1, 1'b0, 8'h20, 8'h00, 1, 1'b0, "rd20");

        // Back-to-back write then read.
        idle(0, 2);
        access(0, 1'b0, 1'b1, 8'h01, 8'h11, 0, 1'b0, "b2b wr01");
        access(0, 1'b1, 1'b0, 8'h01, 8'h00, 1, 1'b0, "b2b rd01");

        // Randomized traffic on the LATENCY=5 instance.
        for (int i = 0; i < 30; i++) begin
            op  = $urandom_range(0, 2);
            b2b = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            if (!b2b) idle(0, $urandom_range(1, 3));
            access(0, op != 1, op != 0, a, 8'($urandom), b2b ? 1 : 0, 1'b1, "rand0");
        end
        idle(0, 1);

        // Randomized traffic on the LATENCY=1 instance.
        for (int i = 0; i < 10; i++) begin
            op  = $urandom_range(0, 2);
            b2b = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            a   = 8'($urandom_range(0, 3));
            if (!b2b && i != 0) idle(1, $urandom_range(1, 2));
            access(1, op != 1, op != 0, a, 8'($urandom), b2b ? 1 : 0, 1'b1, "rand1");
        end
        idle(1, 1);

        // Reset in the middle of a write: the write must not land.
        @(negedge clk);
        wr_in[0] = 1'b1; rd_in[0] = 1'b0; addr_in[0] = 8'hFF; wdata_in[0] = 8'h55;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        wr_in[0] = 1'b0;
        #1;
        clear_model();
        check("midrst rdata0", rdata_out[0], 8'h00);
        check("midrst rdata1", rdata_out[1], 8'h00);
        check("midrst busy0", busy_out[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst busy0", busy_out[0], 1'b0);
        access(0, 1'b1, 1'b0, 8'hFF, 8'h00, 0, 1'b0, "rdFF after rst");
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, 1, 1'b0, "rd10 after rst");
        idle(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 5, cycles from request acceptance to completion (legal range 1..15).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 READ  input  1  CPU read request, held high until the completing edge.
REQ-005 WRITE  input  1  CPU write request, held high until the completing edge.
REQ-006 ADDRESS  input  8  byte address.
REQ-007 WRITEDATA  input  8  data to store.
REQ-008 READDATA  output  8  registered read result.
REQ-009 BUSYWAIT  output  1  stall to CPU; high while a request is outstanding.

Function
REQ-010 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-011 IDLE: BUSYWAIT SHALL equal (READ | WRITE) combinationally, with no added delay.
REQ-012 IDLE with READ|WRITE at a rising edge: latch ADDRESS, WRITEDATA and the op, load counter with LATENCY-1, go to BUSY.
REQ-013 BUSY: BUSYWAIT SHALL be 1; the counter SHALL decrement once per edge.
REQ-014 BUSY edge with counter==0: commit the access, go to DONE.
  - read: READDATA <= mem[latched addr]
  - write: mem[latched addr] <= latched data
REQ-015 Total stall SHALL be exactly LATENCY+1 rising edges with BUSYWAIT high, counted from the first edge at which the request is visible.
REQ-016 DONE: BUSYWAIT SHALL be 0 and READ/WRITE SHALL be ignored; go to IDLE at the next edge.
REQ-017 Changes on ADDRESS, WRITEDATA, READ or WRITE during BUSY SHALL NOT affect the committed access.
REQ-018 If READ and WRITE are both high at acceptance, WRITE SHALL take priority; no read is performed and READDATA is unchanged.
REQ-019 READDATA SHALL hold its value except at a read commit; a write SHALL NOT modify READDATA.
REQ-020 Storage SHALL be 256 x 8 bits with full 8-bit addressing; there is no wrap or out-of-range case.
REQ-021 A request that reappears in IDLE after DONE SHALL be treated as a new request; back-to-back accesses SHALL have exactly one DONE cycle between them.

Reset
REQ-022 RESET low SHALL immediately force:
  - state IDLE, counter 0, READDATA 8'h00
  - all 256 storage bytes cleared to 8'h00
  - latched op cleared
REQ-023 Reset during BUSY SHALL abort the access; a pending write SHALL NOT commit.
REQ-024 After RESET rises, BUSYWAIT SHALL follow REQ-011.

Structure
REQ-025 The shared package SHALL hold:
  - state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10)
  - DEFAULT_LATENCY=5
  - address width 8, data width 8, counter width 4
REQ-026 The storage array SHALL be a separate sub-module, mem_array_256x8, with synchronous write, indexed read and asynchronous active-low clear; FSM and counter SHALL stay in data_mem_responder.

Verification
REQ-027 Write/read-back: WRITE addr 8'h10 data 8'hA5 -> BUSYWAIT high 6 edges, low 1 cycle; then READ 8'h10 -> READDATA 8'hA5 at completing edge.
REQ-028 Latency: LATENCY=1; READ 8'h00 after reset -> BUSYWAIT high exactly 2 edges, READDATA 8'h00.
REQ-029 Conflict: READ=WRITE=1, addr 8'h20, data 8'h3C, READDATA previously 8'h77 -> READDATA stays 8'h77; later READ 8'h20 returns 8'h3C.
REQ-030 Reset mid-write: WRITE 8'hFF/8'h55, RESET low on 3rd BUSY edge -> BUSYWAIT 0 immediately after RESET rises (no request); READ 8'hFF returns 8'h00.
REQ-031 Address hold: READ 8'h10 (contains 8'hA5), ADDRESS changed to 8'h11 during BUSY -> READDATA 8'hA5.
REQ-032 Back-to-back: WRITE 8'h01/8'h11 then READ 8'h01 with no gap -> one DONE cycle with BUSYWAIT 0 between them; READDATA 8'h11.
